// File: rtl/cpu_defs.sv
// Shared definitions for the Mini SRC control sequencer: opcodes, step states,
// instruction classes and the packed control-strobe bundle.
package cpu_defs;

  localparam int OP_BITS = 5;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_MFHI = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd8
  } state_e;

  typedef struct packed {
    logic aluRr;
    logic aluImm;
    logic ld;
    logic ldi;
    logic st;
    logic mulDiv;
    logic unary;
    logic br;
    logic jr;
    logic inp;
    logic outp;
    logic mflo;
    logic mfhi;
    logic nop;
    logic halt;
  } op_class_t;

  typedef struct packed {
    logic [4:0] aluOp;
    logic pcOut, pcIn, incPc;
    logic marIn, mdrIn, mdrOut, read, write;
    logic irIn;
    logic yIn, rzInHi, rzInLo, rzOutHi, rzOutLo;
    logic gra, grb, grc, rIn, rOut, baOut, rcOut;
    logic hiIn, loIn, hiOut, loOut;
    logic conIn, inPortOut, outPortIn;
  } ctrl_t;

  // Execute steps advance linearly; anything past T7 wraps back to fetch.
  function automatic state_e stepAfter(input state_e s);
    case (s)
      T3:      return T4;
      T4:      return T5;
      T5:      return T6;
      T6:      return T7;
      default: return T0;
    endcase
  endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode-to-class decoder; one-hot output, unknown opcodes map to nop.
module op_class_decode
  import cpu_defs::*;
(
  input  logic [OP_BITS-1:0] opcode_i,
  output op_class_t          opClass_o
);

  always_comb begin
    opClass_o = '0;
    case (opcode_i)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  opClass_o.aluRr  = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI:         opClass_o.aluImm = 1'b1;
      OP_LD:                            opClass_o.ld     = 1'b1;
      OP_LDI:                           opClass_o.ldi    = 1'b1;
      OP_ST:                            opClass_o.st     = 1'b1;
      OP_MUL, OP_DIV:                   opClass_o.mulDiv = 1'b1;
      OP_NEG, OP_NOT:                   opClass_o.unary  = 1'b1;
      OP_BR:                            opClass_o.br     = 1'b1;
      OP_JR:                            opClass_o.jr     = 1'b1;
      OP_IN:                            opClass_o.inp    = 1'b1;
      OP_OUT:                           opClass_o.outp   = 1'b1;
      OP_MFLO:                          opClass_o.mflo   = 1'b1;
      OP_MFHI:                          opClass_o.mfhi   = 1'b1;
      OP_HALT:                          opClass_o.halt   = 1'b1;
      default:                          opClass_o.nop    = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the Mini SRC CPU: one T-step per clock,
// strobes decoded from the step register and IR.
module control_unit
  import cpu_defs::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [IRW-1:0] IR,
  input  logic           CON,
  input  logic           Stop,
  output logic           Run,
  output logic [OPW-1:0] alu_op,
  output logic           PCout, PCin, IncPC,
  output logic           MARin, MDRin, MDRout, Read, Write,
  output logic           IRin,
  output logic           Yin, RZinHi, RZinLo, RZoutHi, RZoutLo,
  output logic           Gra, Grb, Grc, Rin, Rout, BAout, RCout,
  output logic           HIin, LOin, HIout, LOout,
  output logic           CONin, InPortOut, OutPortIn
);

  state_e            state_q, state_d;
  op_class_t         cls;
  ctrl_t             ctrl, ctrlOut;
  logic              done;
  logic [OPW-1:0]    opcode;
  logic              unusedIrBits;

  assign opcode       = IR[IRW-1 -: OPW];
  assign unusedIrBits = ^IR[IRW-OPW-1:0];

  op_class_decode u_decode (
    .opcode_i  (opcode),
    .opClass_o (cls)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= T0;
    else        state_q <= state_d;
  end

  // done marks the final step of the current class; it also catches a class
  // that has no work in this step so the sequencer can never wander.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      T0: begin
        if (Stop) begin
          state_d = HALT;
        end else begin
          ctrl.pcOut = 1'b1; ctrl.marIn = 1'b1; ctrl.incPc = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        ctrl.read = 1'b1; ctrl.mdrIn = 1'b1;
        state_d = T2;
      end
      T2: begin
        ctrl.mdrOut = 1'b1; ctrl.irIn = 1'b1;
        if (cls.halt)     state_d = HALT;
        else if (cls.nop) state_d = T0;
        else              state_d = T3;
      end
      T3: begin
        if (cls.aluRr || cls.aluImm) begin ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.yIn = 1'b1; end
        if (cls.ldi || cls.ld || cls.st) begin ctrl.grb = 1'b1; ctrl.baOut = 1'b1; ctrl.yIn = 1'b1; end
        if (cls.mulDiv) begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.yIn = 1'b1; end
        if (cls.unary) begin
          ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.aluOp = opcode; ctrl.rzInLo = 1'b1;
        end
        if (cls.br)   begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.conIn = 1'b1; end
        if (cls.jr)   begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.pcIn = 1'b1; end
        if (cls.inp)  begin ctrl.inPortOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
        if (cls.outp) begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.outPortIn = 1'b1; end
        if (cls.mflo) begin ctrl.loOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
        if (cls.mfhi) begin ctrl.hiOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
        done = !(cls.aluRr || cls.aluImm || cls.ldi || cls.ld || cls.st ||
                 cls.mulDiv || cls.unary || cls.br);
        state_d = done ? T0 : stepAfter(state_q);
      end
      T4: begin
        if (cls.aluRr) begin
          ctrl.grc = 1'b1; ctrl.rOut = 1'b1; ctrl.aluOp = opcode; ctrl.rzInLo = 1'b1;
        end
        if (cls.aluImm) begin ctrl.rcOut = 1'b1; ctrl.aluOp = opcode; ctrl.rzInLo = 1'b1; end
        if (cls.ldi || cls.ld || cls.st) begin
          ctrl.rcOut = 1'b1; ctrl.aluOp = ALU_ADD; ctrl.rzInLo = 1'b1;
        end
        if (cls.mulDiv) begin
          ctrl.grb = 1'b1; ctrl.rOut = 1'b1; ctrl.aluOp = opcode;
          ctrl.rzInHi = 1'b1; ctrl.rzInLo = 1'b1;
        end
        if (cls.unary) begin ctrl.rzOutLo = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
        if (cls.br)    begin ctrl.pcOut = 1'b1; ctrl.yIn = 1'b1; end
        done = !(cls.aluRr || cls.aluImm || cls.ldi || cls.ld || cls.st ||
                 cls.mulDiv || cls.br);
        state_d = done ? T0 : stepAfter(state_q);
      end
      T5: begin
        if (cls.aluRr || cls.aluImm || cls.ldi) begin
          ctrl.rzOutLo = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1;
        end
        if (cls.ld || cls.st) begin ctrl.rzOutLo = 1'b1; ctrl.marIn = 1'b1; end
        if (cls.mulDiv)       begin ctrl.rzOutLo = 1'b1; ctrl.loIn = 1'b1; end
        if (cls.br) begin ctrl.rcOut = 1'b1; ctrl.aluOp = ALU_ADD; ctrl.rzInLo = 1'b1; end
        done = !(cls.ld || cls.st || cls.mulDiv || cls.br);
        state_d = done ? T0 : stepAfter(state_q);
      end
      T6: begin
        if (cls.ld)     begin ctrl.read = 1'b1; ctrl.mdrIn = 1'b1; end
        if (cls.st)     begin ctrl.gra = 1'b1; ctrl.rOut = 1'b1; ctrl.mdrIn = 1'b1; end
        if (cls.mulDiv) begin ctrl.rzOutHi = 1'b1; ctrl.hiIn = 1'b1; end
        if (cls.br && CON) begin ctrl.rzOutLo = 1'b1; ctrl.pcIn = 1'b1; end
        done = !(cls.ld || cls.st);
        state_d = done ? T0 : stepAfter(state_q);
      end
      T7: begin
        if (cls.ld) begin ctrl.mdrOut = 1'b1; ctrl.gra = 1'b1; ctrl.rIn = 1'b1; end
        if (cls.st) ctrl.write = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
      HALT:    state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // clear blanks the strobes combinationally so an abort takes effect mid-step.
  assign ctrlOut   = clear ? ctrl : '0;
  assign Run       = (state_q != HALT);
  assign alu_op    = ctrlOut.aluOp;
  assign PCout     = ctrlOut.pcOut;
  assign PCin      = ctrlOut.pcIn;
  assign IncPC     = ctrlOut.incPc;
  assign MARin     = ctrlOut.marIn;
  assign MDRin     = ctrlOut.mdrIn;
  assign MDRout    = ctrlOut.mdrOut;
  assign Read      = ctrlOut.read;
  assign Write     = ctrlOut.write;
  assign IRin      = ctrlOut.irIn;
  assign Yin       = ctrlOut.yIn;
  assign RZinHi    = ctrlOut.rzInHi;
  assign RZinLo    = ctrlOut.rzInLo;
  assign RZoutHi   = ctrlOut.rzOutHi;
  assign RZoutLo   = ctrlOut.rzOutLo;
  assign Gra       = ctrlOut.gra;
  assign Grb       = ctrlOut.grb;
  assign Grc       = ctrlOut.grc;
  assign Rin       = ctrlOut.rIn;
  assign Rout      = ctrlOut.rOut;
  assign BAout     = ctrlOut.baOut;
  assign RCout     = ctrlOut.rcOut;
  assign HIin      = ctrlOut.hiIn;
  assign LOin      = ctrlOut.loIn;
  assign HIout     = ctrlOut.hiOut;
  assign LOout     = ctrlOut.loOut;
  assign CONin     = ctrlOut.conIn;
  assign InPortOut = ctrlOut.inPortOut;
  assign OutPortIn = ctrlOut.outPortIn;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues one expected output
// vector per clock, a negedge monitor pops and compares.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, CON, Stop;
  logic [31:0] IR;
  logic        Run;
  logic [4:0]  alu_op;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
  logic Yin, RZinHi, RZinLo, RZoutHi, RZoutLo;
  logic Gra, Grb, Grc, Rin, Rout, BAout, RCout;
  logic HIin, LOin, HIout, LOout, CONin, InPortOut, OutPortIn;

  always #5 clock = ~clock;

  control_unit dut (
    .clock(clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop),
    .Run(Run), .alu_op(alu_op),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .IRin(IRin),
    .Yin(Yin), .RZinHi(RZinHi), .RZinLo(RZinLo), .RZoutHi(RZoutHi), .RZoutLo(RZoutLo),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .RCout(RCout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .CONin(CONin), .InPortOut(InPortOut), .OutPortIn(OutPortIn)
  );

  wire [33:0] obsVec = {Run, alu_op, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
                        IRin, Yin, RZinHi, RZinLo, RZoutHi, RZoutLo, Gra, Grb, Grc, Rin, Rout,
                        BAout, RCout, HIin, LOin, HIout, LOout, CONin, InPortOut, OutPortIn};

  localparam logic [33:0] RUN   = 34'd1 << 33;
  localparam logic [33:0] PCO   = 34'd1 << 27, PCI  = 34'd1 << 26, INC  = 34'd1 << 25;
  localparam logic [33:0] MARI  = 34'd1 << 24, MDRI = 34'd1 << 23, MDRO = 34'd1 << 22;
  localparam logic [33:0] RD    = 34'd1 << 21, WR   = 34'd1 << 20, IRI  = 34'd1 << 19;
  localparam logic [33:0] YI    = 34'd1 << 18, ZIH  = 34'd1 << 17, ZIL  = 34'd1 << 16;
  localparam logic [33:0] ZOH   = 34'd1 << 15, ZOL  = 34'd1 << 14;
  localparam logic [33:0] GRA   = 34'd1 << 13, GRB  = 34'd1 << 12, GRC  = 34'd1 << 11;
  localparam logic [33:0] RI    = 34'd1 << 10, RO   = 34'd1 << 9,  BAO  = 34'd1 << 8;
  localparam logic [33:0] RCO   = 34'd1 << 7,  HII  = 34'd1 << 6,  LOI  = 34'd1 << 5;
  localparam logic [33:0] HIO   = 34'd1 << 4,  LOO  = 34'd1 << 3,  CONI = 34'd1 << 2;
  localparam logic [33:0] INPO  = 34'd1 << 1,  OUTI = 34'd1 << 0;

  function automatic logic [33:0] aluF(input logic [4:0] op);
    return {1'b0, op, 28'd0};
  endfunction

  logic [33:0] expQ[$];
  string       tagQ[$];
  logic [33:0] plan [24];
  int          checks = 0;
  int          errors = 0;

  task automatic checkOutput(input string tag, input logic [33:0] expVec);
    checks++;
    if (obsVec !== expVec) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obsVec, expVec);
    end
  endtask

  // Monitor: one expected vector per clock while the scoreboard holds entries.
  always @(negedge clock) begin
    if (expQ.size() != 0) checkOutput(tagQ.pop_front(), expQ.pop_front());
  end

  task automatic waitEmpty();
    int budget = 0;
    do begin
      @(negedge clock); #1;
      budget++;
    end while (expQ.size() != 0 && budget < 200);
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: %0d entries left, required 0", expQ.size());
      expQ.delete();
      tagQ.delete();
    end
  endtask

  task automatic pushVec(input string tag, input logic [33:0] v);
    expQ.push_back(v);
    tagQ.push_back(tag);
  endtask

  task automatic doReset(input int nLow);
    waitEmpty();
    @(posedge clock); #1;
    clear = 1'b0;
    Stop  = 1'b0;
    for (int i = 0; i < nLow; i++) pushVec($sformatf("reset%0d", i), RUN);
  endtask

  // Queues plan[0..n-1] then presents the instruction during the upcoming T0.
  task automatic applyStimulus(input string name, input logic [31:0] ir,
                               input logic con, input logic stop, input int n);
    waitEmpty();
    for (int i = 0; i < n; i++) pushVec($sformatf("%s T%0d", name, i), plan[i]);
    @(posedge clock); #1;
    IR    = ir;
    CON   = con;
    Stop  = stop;
    clear = 1'b1;
  endtask

  task automatic loadFetch();
    plan[0] = RUN | PCO | MARI | INC;
    plan[1] = RUN | RD | MDRI;
    plan[2] = RUN | MDRO | IRI;
  endtask

  initial begin
    clear = 1'b1; IR = '0; CON = 1'b0; Stop = 1'b0;
    doReset(2);

    loadFetch(); plan[3] = RUN | GRB | RO | YI;
    applyStimulus("add-abort", 32'h19890000, 1'b0, 1'b0, 4);
    doReset(2);

    loadFetch(); plan[3] = RUN | LOO | GRA | RI;
    applyStimulus("mflo", 32'hC2800000, 1'b0, 1'b0, 4);

    loadFetch();
    plan[3] = RUN | GRB | RO | YI;
    plan[4] = RUN | GRC | RO | aluF(5'b00011) | ZIL;
    plan[5] = RUN | ZOL | GRA | RI;
    applyStimulus("add", 32'h19890000, 1'b0, 1'b0, 6);

    loadFetch();
    plan[3] = RUN | GRB | RO | YI;
    plan[4] = RUN | GRC | RO | aluF(5'b00100) | ZIL;
    plan[5] = RUN | ZOL | GRA | RI;
    applyStimulus("sub", 32'h21890000, 1'b0, 1'b0, 6);

    loadFetch();
    plan[3] = RUN | GRB | RO | YI;
    plan[4] = RUN | RCO | aluF(5'b01100) | ZIL;
    plan[5] = RUN | ZOL | GRA | RI;
    applyStimulus("addi", 32'h60880005, 1'b0, 1'b0, 6);

    loadFetch();
    plan[3] = RUN | GRB | BAO | YI;
    plan[4] = RUN | RCO | aluF(5'b00011) | ZIL;
    plan[5] = RUN | ZOL | GRA | RI;
    applyStimulus("ldi", 32'h08800064, 1'b0, 1'b0, 6);

    loadFetch();
    plan[3] = RUN | GRB | BAO | YI;
    plan[4] = RUN | RCO | aluF(5'b00011) | ZIL;
    plan[5] = RUN | ZOL | MARI;
    plan[6] = RUN | RD | MDRI;
    plan[7] = RUN | MDRO | GRA | RI;
    applyStimulus("ld", 32'h00800010, 1'b0, 1'b0, 8);

    loadFetch();
    plan[3] = RUN | GRB | BAO | YI;
    plan[4] = RUN | RCO | aluF(5'b00011) | ZIL;
    plan[5] = RUN | ZOL | MARI;
    plan[6] = RUN | GRA | RO | MDRI;
    plan[7] = RUN | WR;
    applyStimulus("st", 32'h11000020, 1'b0, 1'b0, 8);

    loadFetch();
    plan[3] = RUN | GRA | RO | YI;
    plan[4] = RUN | GRB | RO | aluF(5'b10000) | ZIH | ZIL;
    plan[5] = RUN | ZOL | LOI;
    plan[6] = RUN | ZOH | HII;
    applyStimulus("mul", 32'h80880000, 1'b0, 1'b0, 7);

    loadFetch();
    plan[3] = RUN | GRB | RO | aluF(5'b10001) | ZIL;
    plan[4] = RUN | ZOL | GRA | RI;
    applyStimulus("neg", 32'h89080000, 1'b0, 1'b0, 5);

    loadFetch();
    plan[3] = RUN | GRA | RO | CONI;
    plan[4] = RUN | PCO | YI;
    plan[5] = RUN | RCO | aluF(5'b00011) | ZIL;
    plan[6] = RUN;
    applyStimulus("br-con0", 32'h99800010, 1'b0, 1'b0, 7);

    plan[6] = RUN | ZOL | PCI;
    applyStimulus("br-con1", 32'h99800010, 1'b1, 1'b0, 7);

    loadFetch(); plan[3] = RUN | GRA | RO | PCI;
    applyStimulus("jr", 32'hA0800000, 1'b0, 1'b0, 4);
    plan[3] = RUN | INPO | GRA | RI;
    applyStimulus("in", 32'hB0800000, 1'b0, 1'b0, 4);
    plan[3] = RUN | GRA | RO | OUTI;
    applyStimulus("out", 32'hB8800000, 1'b0, 1'b0, 4);
    plan[3] = RUN | HIO | GRA | RI;
    applyStimulus("mfhi", 32'hC8800000, 1'b0, 1'b0, 4);

    loadFetch();
    applyStimulus("nop", 32'hD0000000, 1'b0, 1'b0, 3);
    applyStimulus("undef11101", 32'hE8000000, 1'b0, 1'b0, 3);
    applyStimulus("undef10101", 32'hA8000000, 1'b0, 1'b0, 3);
    // The opcode after an undefined one must start at T0 again.
    plan[3] = RUN | LOO | GRA | RI;
    applyStimulus("mflo-after-undef", 32'hC2800000, 1'b0, 1'b0, 4);

    loadFetch();
    for (int i = 3; i < 23; i++) plan[i] = 34'd0;
    applyStimulus("halt", 32'hD8000000, 1'b0, 1'b0, 23);
    doReset(2);
    loadFetch();
    applyStimulus("nop-after-halt", 32'hD0000000, 1'b0, 1'b0, 3);

    plan[0] = RUN;
    for (int i = 1; i < 21; i++) plan[i] = 34'd0;
    applyStimulus("stop", 32'hD0000000, 1'b0, 1'b1, 21);
    doReset(2);
    loadFetch();
    applyStimulus("nop-after-stop", 32'hD0000000, 1'b0, 1'b0, 3);

    waitEmpty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore-style control sequencer for the phase-3 Mini SRC CPU.
- Replaces the hand-scripted per-instruction control stimulus: it reads IR and CON from the datapath and drives every datapath control strobe, one T-step per clock.
- Sits beside datapath in the top-level CPU, with a one-to-one strobe wiring.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- IRW, 32, instruction register width.

Ports:
clock  input  1  system clock; all state updates on rising edge
clear  input  1  asynchronous, active-low reset
IR  input  IRW  current instruction from datapath IR
CON  input  1  branch-condition flip-flop output from datapath
Stop  input  1  external halt request, sampled in T0
Run  output  1  high while executing; low in HALT
alu_op  output  OPW  ALU function select; opcode encoding, ADD code during address/branch calc
PCout, PCin, IncPC  output  1 each  PC bus drive / load / in-place increment
MARin, MDRin, MDRout, Read, Write  output  1 each  memory interface strobes (Read = MDR takes memory, else bus)
IRin  output  1  load IR from bus
Yin, RZinHi, RZinLo, RZoutHi, RZoutLo  output  1 each  Y and Z register strobes
Gra, Grb, Grc, Rin, Rout, BAout, RCout  output  1 each  register-select encoder and C-sign-extend strobes
HIin, LOin, HIout, LOout  output  1 each  HI/LO register strobes
CONin, InPortOut, OutPortIn  output  1 each  CON FF load, input-port bus drive, output-port load

Behaviour:
- State: step counter T0..T7 plus HALT. clear low forces T0, Run = 1, and every strobe and alu_op to 0. The async assert is honoured mid-instruction; the partially executed instruction is abandoned.
- Outputs are a combinational decode of the registered state and IR. Each strobe is high for exactly one full clock and is captured by the datapath on the next rising edge.
- Fetch, common to all opcodes:
  - T0: PCout MARin IncPC. If Stop=1 in T0, the next state is HALT and no strobes are asserted in that T0.
  - T1: Read MDRin.
  - T2: MDRout IRin.
- Opcodes: 00000 ld, 00001 ldi, 00010 st, 00011 add, 00100 sub, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl, 01100 addi, 01101 andi, 01110 ori, 01111 div, 10000 mul, 10001 neg, 10010 not, 10011 br, 10100 jr, 10110 in, 10111 out, 11000 mflo, 11001 mfhi, 11010 nop, 11011 halt.
- Per-class steps (last listed step returns to T0):
  - reg-reg ALU: T3 Grb Rout Yin; T4 Grc Rout alu_op=opcode RZinLo; T5 RZoutLo Gra Rin.
  - immediate: T3 Grb Rout Yin; T4 RCout alu_op=opcode RZinLo; T5 RZoutLo Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 RCout alu_op=ADD RZinLo; T5 RZoutLo Gra Rin.
  - ld: ldi T3–T4; T5 RZoutLo MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st: ld T3–T5; T6 Gra Rout MDRin (Read=0); T7 Write.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout alu_op RZinHi RZinLo; T5 RZoutLo LOin; T6 RZoutHi HIin.
  - neg/not: T3 Grb Rout alu_op RZinLo; T4 RZoutLo Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 RCout alu_op=ADD RZinLo; T6 RZoutLo PCin only if CON=1, otherwise no strobes in T6.
  - jr: T3 Gra Rout PCin.
  - in: T3 InPortOut Gra Rin.
  - out: T3 Gra Rout OutPortIn.
  - mflo: T3 LOout Gra Rin.
  - mfhi: T3 HIout Gra Rin.
  - nop: T2 goes directly to T0.
- Undefined opcodes (10101, 111xx) execute as nop.
- halt: T2 goes to HALT; Run=0, all strobes 0. HALT is left only by clear.
- CON is sampled in T6 only; a CON change in other steps has no effect.
- Two strobes never drive the bus in the same step (at most one *out/BAout/PCout/MDRout/InPortOut per step).

Decomposition:
- Shared package cpu_defs:
  - opcode localparams (OP_LD … OP_HALT);
  - state encodings T0..T7, HALT;
  - ALU_ADD code.
- Sub-module op_class_decode (combinational): opcode → one-hot class (ALU_RR, ALU_IMM, LD, LDI, ST, MULDIV, UNARY, BR, JR, IN, OUT, MFLO, MFHI, NOP, HALT). It is shared with the future pipeline trace monitor.

Test Plan:
- Reset: clear low mid-T4 of an add → all strobes 0 within the same cycle; after release, T0 asserts PCout MARin IncPC.
- mflo r5, IR=0xC2800000 → T3 shows LOout=Gra=Rin=1 with all other bus drivers 0; 4 cycles total, T0 follows.
- add r3,r1,r2, IR=0x19890000 → T3 Grb Rout Yin; T4 Grc Rout alu_op=00011 RZinLo; T5 RZoutLo Gra Rin; 6 cycles total.
- st → T6 MDRin=1 with Read=0; T7 Write=1 only; 8 cycles total.
- br with CON=0 then CON=1 → T6 PCin=0 in the first case; T6 RZoutLo PCin=1 in the second.
- halt opcode, then separately Stop=1 in T0 → Run falls to 0, strobes stay 0 for 20 cycles; clear pulse restarts fetch at T0.
